uart_imem_loader: RTL and testbench



---
 rtl/uart_imem_loader.sv | 139 +++++++++++++
 tb/tb_uart_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: boot loader that takes a framed UART image and writes it into the core's instruction memory.
// Ports: clk/rst (sync, active-high); uart_rx (async serial in, 8N1, idle high);
//        imem_we/imem_addr/imem_wdata (instruction memory write port, word addressed);
//        core_rst (holds core in reset until a verified image is loaded); load_done/load_error (status).
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_error
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} ld_t;
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  HDR  = 8'hA5;
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  rx_t         r_rx_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_rx_shift;
  ld_t         r_state;
  logic [7:0]  r_count, r_words, r_xor;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic        w_stop_tick, w_byte_valid, w_frame_err, w_cks_ok;
  logic [31:0] w_word_next;
  assign w_stop_tick  = r_rx_state == RX_STOP && r_clk_cnt == FULL;
  assign w_byte_valid = w_stop_tick && r_rx_sync;
  assign w_frame_err  = w_stop_tick && !r_rx_sync;
  // little-endian assembly: the first byte of a word ends up in bits [7:0]
  assign w_word_next  = {r_rx_shift, r_word[31:8]};
  assign w_cks_ok     = r_rx_shift == r_xor;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_sync) begin
          r_rx_state <= RX_START;
          r_clk_cnt  <= '0;
        end
        // a start bit that is high again at mid-bit was a glitch
        RX_START: if (r_clk_cnt == HALF) begin
          r_clk_cnt  <= '0;
          r_bit_idx  <= '0;
          r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
        end else r_clk_cnt <= r_clk_cnt + 16'd1;
        RX_DATA: if (r_clk_cnt == FULL) begin
          r_clk_cnt  <= '0;
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_bit_idx  <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
        end else r_clk_cnt <= r_clk_cnt + 16'd1;
        RX_STOP: if (r_clk_cnt == FULL) r_rx_state <= RX_IDLE;
          else r_clk_cnt <= r_clk_cnt + 16'd1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_words    <= '0;
      r_xor      <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      // address advances right after each strobe so it always points at the next slot
      if (imem_we) imem_addr <= imem_addr + ADDR_WIDTH'(1);
      if (w_frame_err && (r_state == COUNT || r_state == DATA || r_state == CHECK)) begin
        r_state    <= ERROR;
        load_error <= 1'b1;
        core_rst   <= 1'b1;
      end else if (w_byte_valid) begin
        case (r_state)
          IDLE: if (r_rx_shift == HDR) r_state <= COUNT;
          COUNT: begin
            r_count    <= r_rx_shift;
            r_words    <= '0;
            r_byte_idx <= '0;
            r_xor      <= '0;
            imem_addr  <= '0;
            r_state    <= DATA;
          end
          DATA: begin
            r_word     <= w_word_next;
            r_xor      <= r_xor ^ r_rx_shift;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= w_word_next;
              r_words    <= r_words + 8'd1;
              // a count of 0 means 256 words: 0 - 1 wraps to 255
              if (r_words == r_count - 8'd1) r_state <= CHECK;
            end
          end
          CHECK: begin
            r_state    <= w_cks_ok ? DONE : ERROR;
            load_done  <= w_cks_ok;
            load_error <= !w_cks_ok;
            core_rst   <= !w_cks_ok;
          end
          DONE, ERROR: if (r_rx_shift == HDR) begin
            r_state    <= COUNT;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed bench for uart_imem_loader, frame-level model plus per-cycle write checks.
module tb_uart_imem_loader;
  localparam int CPB = 16;
  localparam int AW  = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst, load_done, load_error;
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_writes = 0;
  int            last_addr = -1;
  logic [31:0]   last_data = '0;
  int            exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [31:0]   img[0:7];
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) prev_we = 1'b0;
    else begin
      chk("core_rst_vs_done", 32'(core_rst), 32'(!load_done));
      chk("done_err_exclusive", 32'(load_done & load_error), 32'd0);
      if (prev_we) begin
        chk("we_single_cycle", 32'(imem_we), 32'd0);
        chk("addr_increment", 32'(imem_addr), 32'(AW'(prev_addr + 1'b1)));
      end
      if (imem_we) begin
        n_writes++;
        if (exp_data_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_addr, imem_wdata);
        end else begin
          chk("wr_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
          chk("wr_data", imem_wdata, exp_data_q.pop_front());
        end
        last_addr = int'(imem_addr);
        last_data = imem_wdata;
      end
      prev_we   = imem_we;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic push_word(input int k, input logic [31:0] w);
    exp_addr_q.push_back(k % (1 << AW));
    exp_data_q.push_back(w);
  endtask

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = '0;
    for (int k = 0; k < n; k++) x ^= img[k][7:0] ^ img[k][15:8] ^ img[k][23:16] ^ img[k][31:24];
    return x;
  endfunction

  task automatic send_word(input int k, input logic [31:0] w);
    push_word(k, w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1);
  endtask

  task automatic send_frame(input int n, input logic [7:0] flip);
    send_byte(8'hA5, 1'b1);
    send_byte(8'(n), 1'b1);
    for (int k = 0; k < n; k++) send_word(k, img[k]);
    send_byte(img_xor(n) ^ flip, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic status(input string tag, input logic d, input logic e);
    chk({tag, "_load_done"}, 32'(load_done), 32'(d));
    chk({tag, "_load_error"}, 32'(load_error), 32'(e));
    chk({tag, "_core_rst"}, 32'(core_rst), 32'(!d));
    chk({tag, "_pending_writes"}, 32'(exp_data_q.size()), 32'd0);
  endtask

  task automatic glitch();
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    img[0] = 32'h00100513;
    chk("cks_single_model", 32'(img_xor(1)), 32'h06);
    n_writes = 0;
    send_frame(1, 8'h00);
    status("single", 1'b1, 1'b0);
    chk("single_data", last_data, 32'h00100513);
    chk("single_addr", 32'(last_addr), 32'd0);
    chk("single_writes", 32'(n_writes), 32'd1);

    img[0] = 32'h00000093;
    img[1] = 32'h00100113;
    img[2] = 32'h002081B3;
    chk("cks_three_model", 32'(img_xor(3)), 32'h83);
    n_writes = 0;
    send_frame(3, 8'h00);
    status("three", 1'b1, 1'b0);
    chk("three_last_data", last_data, 32'h002081B3);
    chk("three_last_addr", 32'(last_addr), 32'd2);
    chk("three_writes", 32'(n_writes), 32'd3);

    n_writes = 0;
    send_frame(3, 8'h01);
    status("bad_cks", 1'b0, 1'b1);
    chk("bad_cks_writes", 32'(n_writes), 32'd3);
    send_frame(3, 8'h00);
    status("resend", 1'b1, 1'b0);

    n_writes = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    status("frame_err", 1'b0, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1);
    repeat (4) @(negedge clk);
    status("after_frame_err", 1'b0, 1'b1);
    chk("frame_err_writes", 32'(n_writes), 32'd0);

    img[0] = 32'hDEADBEEF;
    n_writes = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    push_word(0, img[0]);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    glitch();
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(img_xor(1), 1'b1);
    repeat (4) @(negedge clk);
    status("glitch_data", 1'b1, 1'b0);
    chk("glitch_data_word", last_data, 32'hDEADBEEF);
    glitch();
    status("glitch_idle", 1'b1, 1'b0);
    chk("glitch_writes", 32'(n_writes), 32'd1);

    n_writes = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int k = 0; k < 6; k++) send_word(k, 32'h10203040 + 32'(k) * 32'h01010101);
    repeat (4) @(negedge clk);
    status("n256_midway", 1'b0, 1'b0);
    chk("n256_writes", 32'(n_writes), 32'd6);
    chk("n256_wrap_addr", 32'(last_addr), 32'd1);
    chk("n256_last_data", last_data, 32'h15253545);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_load_done", 32'(load_done), 32'd0);
    chk("midrst_load_error", 32'(load_error), 32'd0);
    chk("midrst_imem_we", 32'(imem_we), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    status("garbage", 1'b0, 1'b0);
    img[0] = 32'h00100513;
    n_writes = 0;
    send_frame(1, 8'h00);
    status("post_rst", 1'b1, 1'b0);
    chk("post_rst_addr", 32'(last_addr), 32'd0);
    chk("post_rst_writes", 32'(n_writes), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
